// File: rtl/multimode_display_signal.sv
// Four-preset display sync generator with frame-boundary mode switching.
// Optional o_line_start output is enabled by defining MMDS_LINE_START_EN.
module multimode_display_signal #(
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned COORD_W      = 13,
    parameter logic [3:0]  MODE_MASK    = 4'b1111
) (
    input  logic                      i_pixel_clk,
    input  logic                      i_reset_n,
    input  logic [1:0]                i_mode,
    input  logic                      i_mode_req,
    output logic [1:0]                o_mode,
    output logic                      o_mode_busy,
    output logic                      o_mode_err,
    output logic [2:0]                o_hvesync,
    output logic                      o_frame_start,
`ifdef MMDS_LINE_START_EN
    output logic                      o_line_start,
`endif
    output logic signed [COORD_W-1:0] o_x,
    output logic signed [COORD_W-1:0] o_y
);

    // state   | meaning
    // IDLE    | no switch request outstanding
    // PENDING | request latched in pend, applied at the next frame wrap

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef enum logic { IDLE = 1'b0, PENDING = 1'b1 } state_t;

    localparam int HFP  [4] = '{16, 40, 110, 88};
    localparam int HSW  [4] = '{96, 128, 40, 44};
    localparam int HBP  [4] = '{48, 88, 220, 148};
    localparam int HRES [4] = '{640, 800, 1280, 1920};
    localparam int VFP  [4] = '{10, 1, 5, 4};
    localparam int VSW  [4] = '{2, 4, 5, 5};
    localparam int VBP  [4] = '{33, 23, 20, 36};
    localparam int VRES [4] = '{480, 600, 720, 1080};
    localparam logic [3:0] POL      = 4'b1110;
    localparam logic [1:0] DEF_MODE = DEFAULT_MODE[1:0];
    localparam coord_t     ONE      = coord_t'(1);

    state_t     state, state_n;
    logic [1:0] pend, pend_n, mode_n;
    logic       err_n, line_end, wrap;
    coord_t     hres_cur, vres_cur;
    coord_t     hbp_n, hsw_n, hb_n, vbp_n, vsw_n, vb_n;
    coord_t     x_n, y_n;
    logic       de_n, hs_act, vs_act, pol_n;

    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            pend  <= DEF_MODE;
        end else begin
            state <= state_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n  = state;
        pend_n   = pend;
        mode_n   = o_mode;
        err_n    = 1'b0;
        hres_cur = coord_t'(HRES[o_mode]);
        vres_cur = coord_t'(VRES[o_mode]);
        line_end = (o_x == hres_cur - ONE);
        wrap     = line_end && (o_y == vres_cur - ONE);
        if (wrap && state == PENDING) begin
            mode_n  = pend;
            state_n = IDLE;
        end
        // A request landing on the wrap cycle is latched after the swap, so it waits a frame.
        if (i_mode_req) begin
            if (MODE_MASK[i_mode]) begin
                pend_n  = i_mode;
                state_n = PENDING;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    assign o_mode_busy = (state == PENDING);

    always_comb begin
        hbp_n = coord_t'(HBP[mode_n]);
        hsw_n = coord_t'(HSW[mode_n]);
        hb_n  = coord_t'(HFP[mode_n]) + hsw_n + hbp_n;
        vbp_n = coord_t'(VBP[mode_n]);
        vsw_n = coord_t'(VSW[mode_n]);
        vb_n  = coord_t'(VFP[mode_n]) + vsw_n + vbp_n;
        pol_n = POL[mode_n];
        x_n   = o_x + ONE;
        y_n   = o_y;
        if (line_end) begin
            x_n = -hb_n;
            y_n = wrap ? -vb_n : o_y + ONE;
        end
        de_n   = ~x_n[COORD_W-1] & ~y_n[COORD_W-1];
        hs_act = (x_n >= -(hsw_n + hbp_n)) && (x_n < -hbp_n);
        vs_act = (y_n >= -(vsw_n + vbp_n)) && (y_n < -vbp_n);
    end

    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            o_mode        <= DEF_MODE;
            o_x           <= coord_t'(HRES[DEF_MODE]) - ONE;
            o_y           <= coord_t'(VRES[DEF_MODE]) - ONE;
            o_hvesync     <= {1'b0, ~POL[DEF_MODE], ~POL[DEF_MODE]};
            o_frame_start <= 1'b0;
            o_mode_err    <= 1'b0;
        end else begin
            o_mode        <= mode_n;
            o_x           <= x_n;
            o_y           <= y_n;
            o_hvesync     <= {de_n, vs_act ? pol_n : ~pol_n, hs_act ? pol_n : ~pol_n};
            o_frame_start <= wrap;
            o_mode_err    <= err_n;
        end
    end

`ifdef MMDS_LINE_START_EN
    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            o_line_start <= 1'b0;
        end else begin
            o_line_start <= line_end;
        end
    end
`endif

endmodule

// File: doc/multimode_display_signal.md
Name: multimode_display_signal

Overview:
- Parametrised successor to the single-mode display sync generator.
- Holds four hard-wired timing presets (640x480, 800x600, 1280x720, 1920x1080) and switches between them at run time.
- A switch request is accepted at any time and applied only at a frame boundary, so the sink never sees a torn frame.
- Sits between the pixel-clock domain and the pattern/HDMI encoder. o_mode also drives the external pixel-clock selection logic.

Parameters:
- DEFAULT_MODE, 0: preset loaded at reset (0=640x480, 1=800x600, 2=1280x720, 3=1920x1080).
- COORD_W, 13: width of signed o_x/o_y; must hold -2200..2199.
- MODE_MASK, 4'b1111: bit n set means preset n may be selected at run time.

Ports:
- i_pixel_clk  in  1  pixel clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_mode  in  2  requested preset, sampled when i_mode_req=1.
- i_mode_req  in  1  one-cycle request strobe.
- o_mode  out  2  preset currently driving timing.
- o_mode_busy  out  1  request pending, not yet applied.
- o_mode_err  out  1  one-cycle pulse: request rejected by MODE_MASK.
- o_hvesync  out  3  {display enable, vsync, hsync}.
- o_frame_start  out  1  one-cycle pulse at frame origin.
- o_x  out  COORD_W  signed horizontal position.
- o_y  out  COORD_W  signed vertical position.

Behaviour:
- Interface: one clock (i_pixel_clk). Reset i_reset_n is synchronous and active-low.
- Preset tables, as HFP/HSYNC/HBP/HRES, VFP/VSYNC/VBP/VRES, polarity:
  - m0: 16/96/48/640, 10/2/33/480, pol 0.
  - m1: 40/128/88/800, 1/4/23/600, pol 1.
  - m2: 110/40/220/1280, 5/5/20/720, pol 1.
  - m3: 88/44/148/1920, 4/5/36/1080, pol 1.
- Blanking widths: HB = HFP+HSYNC+HBP, VB = VFP+VSYNC+VBP.
- Coordinates:
  - x runs -HB..HRES-1; y runs -VB..VRES-1.
  - x increments every cycle; at x=HRES-1, x wraps to -HB and y increments.
  - At y=VRES-1 with x=HRES-1, y wraps to -VB (frame wrap).
- Outputs are all registered and mutually aligned: in any cycle, o_hvesync describes pixel (o_x,o_y).
- Display enable: 1 iff x>=0 and y>=0.
- hsync: active (level = pol) iff x in [-HB+HFP, -HB+HFP+HSYNC-1]; otherwise ~pol.
  - m0 example: x in -144..-49.
- vsync: active iff y in [-VB+VFP, -VB+VFP+VSYNC-1], for every cycle of those lines.
  - m0 example: y -35..-34.
- o_frame_start: 1 iff (o_x,o_y)=(-HB,-VB).
- Reset (i_reset_n=0 at clock edge):
  - o_mode=DEFAULT_MODE; o_x=HRES-1 and o_y=VRES-1 of that mode.
  - o_hvesync={0, ~pol, ~pol}.
  - o_frame_start=0, o_mode_busy=0, o_mode_err=0; pending request cleared.
  - The first cycle after release is the frame origin, with o_frame_start=1.
  - Reset mid-frame or mid-switch abandons the pending request.
- Mode request state machine, states IDLE and PENDING:
  - i_mode_req with MODE_MASK[i_mode]=1: latch i_mode into pending; PENDING; o_mode_busy=1 from the next cycle.
  - i_mode_req with MODE_MASK[i_mode]=0: o_mode_err=1 next cycle; state and pending unchanged.
  - Request while PENDING overwrites pending (last wins).
  - Request equal to current o_mode is accepted normally; the frame restarts identically.
  - PENDING at frame wrap: the origin cycle uses the new preset's HB/VB/pol.
    - o_mode updates and o_mode_busy drops in that origin cycle; back to IDLE.
  - Request in the same cycle as the frame wrap is not applied at that wrap; it is applied at the next wrap.
- Latency: a request is applied at the first frame wrap strictly after it. Worst case is one full frame plus 1 cycle.

Optional Feature:
- Macro MMDS_LINE_START_EN.
  - Defined: adds output o_line_start (1 bit), registered and aligned. o_line_start=1 iff o_x=-HB on any line, including the origin. Reset value 0.
  - Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset DEFAULT_MODE=0, release -> first cycle o_x=-160, o_y=-45, o_frame_start=1. Next origin pulse exactly 420000 cycles later.
- Mode 0 line scan -> hsync=0 exactly for x=-144..-49 (96 cycles). DE=1 for 640 cycles per active line. vsync=0 for y=-35,-34 only.
- Request i_mode=2 mid-frame -> o_mode_busy=1 until the next wrap. Then o_mode=2, o_x=-370, o_y=-30, hsync idle 0, frame length 1237500 cycles.
- Requests 1 then 3 within one frame -> only mode 3 applied at the wrap. Request coincident with a wrap cycle -> applied one frame later.
- MODE_MASK=4'b0011, request 3 -> o_mode_err one-cycle pulse, o_mode_busy stays 0, timing unchanged.
- Reset asserted while PENDING -> after release o_mode=DEFAULT_MODE, o_mode_busy=0. With MMDS_LINE_START_EN: 525 o_line_start pulses per mode-0 frame.
